// File: rtl/aes_decryption.sv
// Iterative AES-128 inverse cipher, one round per clock, round keys fetched in reverse order.
// Optional macro AES_DEC_ZEROIZE_EN: plaintext and state are wiped one cycle after delivery.
module aes_decryption #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned KEY_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_fifo,
  input  logic                  is_full,
  input  logic [127:0]          fifo_in,
  input  logic [127:0]          round_key_input,
  input  logic [127:0]          round_key_0,
  output logic [KEY_ADDR_W-1:0] round_key_addr,
  output logic [127:0]          data_output,
  output logic                  data_done,
  output logic                  data_valid
);

  localparam int unsigned RND_W = 4;

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, WAIT_OUT} fsm_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // InvShiftRows then InvSubBytes; byte index = 4*col + row
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = INV_SBOX[s[127-8*(4*((c-r+4)%4)+r) -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   a2 [4];
    logic [7:0]   a4 [4];
    logic [7:0]   a8 [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = s[127-8*(4*c+r) -: 8];
        a2[r] = xt(a[r]);
        a4[r] = xt(a2[r]);
        a8[r] = xt(a4[r]);
      end
      // 0e = 8^4^2, 0b = 8^2^1, 0d = 8^4^1, 09 = 8^1
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] =
            (a8[r] ^ a4[r] ^ a2[r]) ^
            (a8[(r+1)%4] ^ a2[(r+1)%4] ^ a[(r+1)%4]) ^
            (a8[(r+2)%4] ^ a4[(r+2)%4] ^ a[(r+2)%4]) ^
            (a8[(r+3)%4] ^ a[(r+3)%4]);
      end
    end
    return o;
  endfunction

  fsm_e                  fsm_q, fsm_d;
  logic [127:0]          state_q, state_d;
  logic [RND_W-1:0]      rnd_q, rnd_d;
  logic [KEY_ADDR_W-1:0] addr_q, addr_d;
  logic [127:0]          out_q, out_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;
  logic [127:0]          shift_sub;
  logic [127:0]          round_res;
  logic [127:0]          final_res;

  assign shift_sub = inv_shift_sub(state_q);
  assign round_res = inv_mix(shift_sub ^ round_key_input);
  assign final_res = shift_sub ^ round_key_0;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    addr_d  = addr_q;
    out_d   = out_q;
    done_d  = 1'b0;
    valid_d = valid_q;
`ifdef AES_DEC_ZEROIZE_EN
    if (done_q) begin
      out_d   = '0;
      valid_d = 1'b0;
    end
`endif
    case (fsm_q)
      IDLE: begin
        addr_d = KEY_ADDR_W'(NUM_ROUNDS - 1);
        if (read_fifo) begin
          state_d = fifo_in;
          valid_d = 1'b0;
          addr_d  = KEY_ADDR_W'(NUM_ROUNDS - 2);
          fsm_d   = INIT;
        end
      end
      INIT: begin
        state_d = state_q ^ round_key_input;
        rnd_d   = RND_W'(NUM_ROUNDS - 1);
        addr_d  = KEY_ADDR_W'(NUM_ROUNDS - 3);
        fsm_d   = ROUND;
      end
      ROUND: begin
        state_d = round_res;
        addr_d  = (rnd_q > RND_W'(3)) ? KEY_ADDR_W'(rnd_q - RND_W'(3)) : '0;
        rnd_d   = rnd_q - RND_W'(1);
        if (rnd_q == RND_W'(1)) fsm_d = FINAL;
      end
      FINAL: begin
        if (!is_full) begin
          out_d   = final_res;
          done_d  = 1'b1;
          valid_d = 1'b1;
          addr_d  = KEY_ADDR_W'(NUM_ROUNDS - 1);
          fsm_d   = IDLE;
`ifdef AES_DEC_ZEROIZE_EN
          state_d = '0;
`endif
        end else begin
          state_d = final_res;
          fsm_d   = WAIT_OUT;
        end
      end
      WAIT_OUT: begin
        if (!is_full) begin
          out_d   = state_q;
          done_d  = 1'b1;
          valid_d = 1'b1;
          addr_d  = KEY_ADDR_W'(NUM_ROUNDS - 1);
          fsm_d   = IDLE;
`ifdef AES_DEC_ZEROIZE_EN
          state_d = '0;
`endif
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
      addr_q  <= KEY_ADDR_W'(NUM_ROUNDS - 1);
      out_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign round_key_addr = addr_q;
  assign data_output    = out_q;
  assign data_done      = done_q;
  assign data_valid     = valid_q;

endmodule

// File: doc/aes_decryption.md
Name: aes_decryption

Overview:
- Iterative AES-128 inverse cipher; one round per clock. Counterpart of aes_encryption on the same FIFO / round-key interface.
- Takes a 128-bit ciphertext from the input FIFO and fetches round keys in reverse order from the shared round-key store.
- Delivers the plaintext to the downstream FIFO with a done pulse and a valid level.

Parameters:
- NUM_ROUNDS, 10, AES-128 round count; only 10 is supported.
- KEY_ADDR_W, 4, width of round_key_addr.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- read_fifo  input  1  input FIFO holds a ciphertext block on fifo_in; sampled only in IDLE.
- is_full  input  1  downstream FIFO full; result is held back while high.
- fifo_in  input  128  ciphertext; bits [127:120] = byte 0, FIPS-197 column-major order.
- round_key_input  input  128  key-store data; value in cycle n+1 = key[round_key_addr in cycle n].
- round_key_0  input  128  cipher key (round key 0), static.
- round_key_addr  output  KEY_ADDR_W  key-store address; address a returns round key a+1 (0..9 -> keys 1..10).
- data_output  output  128  plaintext.
- data_done  output  1  one-cycle pulse when data_output is loaded.
- data_valid  output  1  data_output holds an unconsumed result.

Behaviour:
- Reset values when rst=1 at a clk edge:
  - state register = IDLE
  - round_key_addr = 9
  - data_output = 0
  - data_done = 0
  - data_valid = 0
  - round counter = 0
  - An operation in progress is abandoned; no data_done.
- FSM states: IDLE, INIT, ROUND, FINAL, WAIT_OUT.
- IDLE:
  - round_key_addr = 9.
  - On read_fifo=1: capture fifo_in into the state register, clear data_valid (without AES_DEC_ZEROIZE_EN), set round_key_addr to 8, go to INIT.
- INIT (key 10 on round_key_input):
  - state ^= round_key_input
  - rnd <= 9, round_key_addr <= 7, go to ROUND.
- ROUND r (key r on round_key_input):
  - state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key_input).
  - round_key_addr <= max(r-3, 0); rnd <= r-1.
  - At r=1 go to FINAL.
- FINAL:
  - result = InvSubBytes(InvShiftRows(state)) ^ round_key_0.
  - If is_full=0: data_output <= result, data_done <= 1, data_valid <= 1, round_key_addr <= 9, go to IDLE.
  - Else: store result in state and go to WAIT_OUT.
- WAIT_OUT:
  - Hold until is_full=0, then load data_output, pulse data_done, set data_valid, go to IDLE.
  - Wait is unbounded.
- Latency: read_fifo in cycle 0 -> data_done and data_output visible in cycle 12 when is_full=0; each is_full cycle adds one.
- Throughput: one block per 12 cycles. A new block can be accepted in the cycle data_done is high.
- read_fifo outside IDLE is ignored; the upstream FIFO must hold its data.
- data_done is never high two consecutive cycles.
- data_output changes only at a data_done load, or at rst.
- InvSubBytes uses a combinational 256-entry inverse S-box on all 16 bytes.
- InvMixColumns coefficients are {0e,0b,0d,09} over GF(2^8), reduction polynomial 0x11b.
- is_full is ignored in every state except FINAL and WAIT_OUT.

Optional Feature:
- Macro: AES_DEC_ZEROIZE_EN.
- Defined:
  - data_output is zeroed and data_valid cleared the cycle after data_done, so data_valid equals data_done.
  - The internal state register is zeroed on the same edge as the load.
  - No plaintext persists more than one cycle.
- Undefined:
  - data_output and data_valid hold until the next read_fifo acceptance in IDLE clears data_valid.
  - data_output itself holds until overwritten or rst.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f (bench models key store with 1-cycle read latency), fifo_in 69c4e0d86a7b0430d8cdb78070b4c55a, read_fifo 1 cycle -> data_output 00112233445566778899aabbccddeeff, data_done exactly in cycle 12, single pulse.
- Key addressing: during the above, round_key_addr sequence from cycle 0 is 9,8,7,6,5,4,3,2,1,0,0,0 then back to 9 in IDLE.
- Back-pressure: is_full=1 from cycle 10 to 15, released in cycle 16 -> data_done in cycle 17, correct plaintext, no pulse before.
- Busy ignore and back-to-back: read_fifo held high with a different ciphertext during cycles 1-11 -> ignored. Second block accepted in cycle 12 -> its result in cycle 24. Both match an encryption-model round trip of 500 random blocks.
- Reset mid-operation: rst=1 in cycle 6 -> next cycle data_done=0, data_valid=0, data_output=0, round_key_addr=9. A fresh block afterwards decrypts correctly.
- Macro check: with AES_DEC_ZEROIZE_EN, data_valid is high one cycle and data_output=0 the cycle after data_done. Without it, data_output holds 00112233445566778899aabbccddeeff for 20+ idle cycles.
